mmss_timer: RTL and testbench

MMSS_TIMER -- requirements
Module: mmss_timer

---
 rtl/mmss_timer_if.sv | 24 ++
 rtl/mmss_timer.sv | 139 +++++++++++++
 tb/tb_mmss_timer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmss_timer_if.sv
// Control inputs and time outputs of the mm:ss timer, grouped as one bus.
// The driver side uses master; the timer itself uses slave.
interface mmss_timer_if #(
  parameter int FIELD_W = 6
);
  logic               enable;
  logic               adj;
  logic               sel;
  logic               dir;
  logic [FIELD_W-1:0] minutes;
  logic [FIELD_W-1:0] seconds;
  logic               sec_tick;
  logic               wrap;

  modport master (
    output enable, adj, sel, dir,
    input  minutes, seconds, sec_tick, wrap
  );

  modport slave (
    input  enable, adj, sel, dir,
    output minutes, seconds, sec_tick, wrap
  );
endinterface

// File: rtl/mmss_timer.sv
// Minutes:seconds up/down timer with a run prescaler and a separate, faster
// adjust prescaler that bumps one selected field at a time.
module mmss_timer #(
  parameter int FIELD_W  = 6,
  parameter int TICK_DIV = 100000000,
  parameter int ADJ_DIV  = 50000000,
  parameter int MIN_MAX  = 59
) (
  input logic         timer,
  input logic         reset,
  mmss_timer_if.slave bus
);

  localparam int P_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int Q_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;

  typedef logic [FIELD_W-1:0] field_t;
  typedef struct packed {
    logic   wrap;
    field_t min;
    field_t sec;
  } step_t;

  localparam logic [P_W-1:0] P_LAST   = P_W'(TICK_DIV - 1);
  localparam logic [P_W-1:0] P_ONE    = P_W'(1);
  localparam logic [Q_W-1:0] Q_LAST   = Q_W'(ADJ_DIV - 1);
  localparam logic [Q_W-1:0] Q_ONE    = Q_W'(1);
  localparam field_t         SEC_LAST = field_t'(59);
  localparam field_t         MIN_LAST = field_t'(MIN_MAX);
  localparam field_t         F_ONE    = field_t'(1);
  localparam field_t         F_ZERO   = '0;

  logic [P_W-1:0] r_p, w_p;
  logic [Q_W-1:0] r_q, w_q;
  field_t         r_min, w_min;
  field_t         r_sec, w_sec;
  logic           r_tick, w_tick;
  logic           r_wrap, w_wrap;
  step_t          w_step;

  function automatic step_t count_up(input field_t m, input field_t s);
    step_t r;
    r.wrap = 1'b0;
    r.min  = m;
    r.sec  = s + F_ONE;
    if (s >= SEC_LAST) begin
      r.sec = F_ZERO;
      if (m >= MIN_LAST) begin
        r.min  = F_ZERO;
        r.wrap = 1'b1;
      end else begin
        r.min = m + F_ONE;
      end
    end
    return r;
  endfunction

  function automatic step_t count_down(input field_t m, input field_t s);
    step_t r;
    r.wrap = 1'b0;
    r.min  = m;
    r.sec  = s - F_ONE;
    if (s == F_ZERO) begin
      r.sec = SEC_LAST;
      if (m == F_ZERO) begin
        r.min  = MIN_LAST;
        r.wrap = 1'b1;
      end else begin
        r.min = m - F_ONE;
      end
    end
    return r;
  endfunction

  // Adjust steps roll a single field over without carrying into the other.
  function automatic field_t adj_inc(input field_t v, input field_t last);
    return (v >= last) ? F_ZERO : v + F_ONE;
  endfunction

  always_comb begin
    w_p    = r_p;
    w_q    = r_q;
    w_min  = r_min;
    w_sec  = r_sec;
    w_tick = 1'b0;
    w_wrap = 1'b0;
    w_step = '0;
    if (bus.adj) begin
      w_p = '0;
      if (r_q == Q_LAST) begin
        w_q    = '0;
        w_tick = 1'b1;
        if (bus.sel) w_sec = adj_inc(r_sec, SEC_LAST);
        else         w_min = adj_inc(r_min, MIN_LAST);
      end else begin
        w_q = r_q + Q_ONE;
      end
    end else begin
      // Pausing simply freezes p, so the partial second survives.
      w_q = '0;
      if (bus.enable) begin
        if (r_p == P_LAST) begin
          w_p    = '0;
          w_tick = 1'b1;
          w_step = bus.dir ? count_down(r_min, r_sec) : count_up(r_min, r_sec);
          w_min  = w_step.min;
          w_sec  = w_step.sec;
          w_wrap = w_step.wrap;
        end else begin
          w_p = r_p + P_ONE;
        end
      end
    end
  end

  always_ff @(posedge timer) begin
    if (!reset) begin
      r_p    <= '0;
      r_q    <= '0;
      r_min  <= '0;
      r_sec  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_p    <= w_p;
      r_q    <= w_q;
      r_min  <= w_min;
      r_sec  <= w_sec;
      r_tick <= w_tick;
      r_wrap <= w_wrap;
    end
  end

  assign bus.minutes  = r_min;
  assign bus.seconds  = r_sec;
  assign bus.sec_tick = r_tick;
  assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_mmss_timer.sv
// Bench for mmss_timer with small dividers; a time-in-seconds reference model
// predicts every cycle, and directed scenarios pin the spec's example values.
module tb_mmss_timer;
  localparam int FW       = 6;
  localparam int TICK_DIV = 4;
  localparam int ADJ_DIV  = 2;
  localparam int MIN_MAX  = 2;
  localparam int RANGE    = (MIN_MAX + 1) * 60;

  logic timer = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state: displayed time and prescaler phases
  int   mmin = 0, msec = 0, mp = 0, mq = 0;
  logic et = 1'b0, ew = 1'b0;

  mmss_timer_if #(.FIELD_W(FW)) bus ();

  mmss_timer #(
    .FIELD_W (FW),
    .TICK_DIV(TICK_DIV),
    .ADJ_DIV (ADJ_DIV),
    .MIN_MAX (MIN_MAX)
  ) dut (
    .timer(timer),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  always #5 timer = ~timer;

  function automatic logic [2*FW+1:0] dut_vec();
    return {bus.minutes, bus.seconds, bus.sec_tick, bus.wrap};
  endfunction

  function automatic logic [2*FW+1:0] mdl_vec();
    return {FW'(mmin), FW'(msec), et, ew};
  endfunction

  task automatic model_edge();
    int tot;
    et = 1'b0;
    ew = 1'b0;
    if (!rst_n) begin
      mmin = 0; msec = 0; mp = 0; mq = 0;
    end else if (bus.adj) begin
      mp = 0;
      if (mq == ADJ_DIV - 1) begin
        mq = 0;
        et = 1'b1;
        if (bus.sel) msec = (msec + 1) % 60;
        else         mmin = (mmin + 1) % (MIN_MAX + 1);
      end else begin
        mq++;
      end
    end else begin
      mq = 0;
      if (bus.enable) begin
        if (mp == TICK_DIV - 1) begin
          mp  = 0;
          et  = 1'b1;
          tot = mmin * 60 + msec;
          if (!bus.dir) begin
            tot = (tot + 1) % RANGE;
            ew  = (tot == 0);
          end else begin
            ew  = (tot == 0);
            tot = (tot + RANGE - 1) % RANGE;
          end
          mmin = tot / 60;
          msec = tot % 60;
        end else begin
          mp++;
        end
      end
    end
  endtask

  // Advance one clock, update the model at the edge, then settle before sampling.
  task automatic cycle();
    @(posedge timer);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enable = 1'($urandom_range(0, 1));
      bus.adj    = 1'($urandom_range(0, 1));
      bus.sel    = 1'($urandom_range(0, 1));
      bus.dir    = 1'($urandom_range(0, 1));
      cycle();
      n_total++;
      if (dut_vec() !== '0) $display("FAIL reset_state cyc=%0d got=%h exp=0", i, dut_vec());
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    do_reset();
    bus.enable = 1'b1; bus.adj = 1'b0; bus.dir = 1'b0; bus.sel = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL count_up edge=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      else n_pass++;
      n_total++;
      if ({bus.seconds, bus.sec_tick} !== {FW'(i / 4), (i % 4) == 0})
        $display("FAIL count_up_spec edge=%0d got sec=%0d tick=%b exp sec=%0d", i, bus.seconds, bus.sec_tick, i / 4);
      else n_pass++;
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    bus.enable = 1'b1; bus.adj = 1'b0; bus.dir = 1'b0;
    for (int i = 1; i <= 724; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL full_wrap edge=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      else n_pass++;
      if (i == 716 || i == 720 || i == 721) begin
        n_total++;
        if (i == 716 && dut_vec() !== {FW'(2), FW'(59), 1'b1, 1'b0})
          $display("FAIL full_wrap_0259 got=%h exp=%h", dut_vec(), {FW'(2), FW'(59), 1'b1, 1'b0});
        else if (i == 720 && dut_vec() !== {FW'(0), FW'(0), 1'b1, 1'b1})
          $display("FAIL full_wrap_pulse got=%h exp=%h", dut_vec(), {FW'(0), FW'(0), 1'b1, 1'b1});
        else if (i == 721 && bus.wrap !== 1'b0)
          $display("FAIL full_wrap_one_cycle got=%b exp=0", bus.wrap);
        else n_pass++;
      end
    end
  endtask

  task automatic test_down();
    do_reset();
    bus.enable = 1'b1; bus.adj = 1'b0; bus.dir = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL down edge=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
    n_total++;
    if (dut_vec() !== {FW'(2), FW'(58), 1'b1, 1'b0})
      $display("FAIL down_0258 got=%h exp=%h", dut_vec(), {FW'(2), FW'(58), 1'b1, 1'b0});
    else n_pass++;
    bus.dir = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    bus.enable = 1'b1; bus.adj = 1'b0; bus.dir = 1'b0;
    cycle(); cycle();
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== '0) $display("FAIL pause_hold cyc=%0d got=%h exp=0", i, dut_vec());
      else n_pass++;
    end
    bus.enable = 1'b1;
    cycle();
    n_total++;
    if (dut_vec() !== '0) $display("FAIL pause_resume1 got=%h exp=0", dut_vec());
    else n_pass++;
    cycle();
    n_total++;
    if (dut_vec() !== {FW'(0), FW'(1), 1'b1, 1'b0})
      $display("FAIL pause_resume2 got=%h exp=%h", dut_vec(), {FW'(0), FW'(1), 1'b1, 1'b0});
    else n_pass++;
  endtask

  task automatic test_adjust();
    do_reset();
    bus.enable = 1'b0; bus.adj = 1'b1; bus.sel = 1'b1; bus.dir = 1'b1;
    for (int i = 1; i <= 118; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL adjust_sec cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      else n_pass++;
    end
    n_total++;
    if (bus.seconds !== FW'(59)) $display("FAIL adjust_to59 got=%0d exp=59", bus.seconds);
    else n_pass++;
    cycle(); cycle();
    n_total++;
    if (dut_vec() !== {FW'(0), FW'(0), 1'b1, 1'b0})
      $display("FAIL adjust_sec_roll got=%h exp=%h", dut_vec(), {FW'(0), FW'(0), 1'b1, 1'b0});
    else n_pass++;
    bus.sel = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL adjust_min cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      else n_pass++;
      if (i == 4 || i == 6) begin
        n_total++;
        if (bus.minutes !== FW'((i == 4) ? 2 : 0) || bus.wrap !== 1'b0)
          $display("FAIL adjust_min_spec cyc=%0d got min=%0d wrap=%b", i, bus.minutes, bus.wrap);
        else n_pass++;
      end
    end
    bus.adj = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.enable = 1'b1; bus.adj = 1'b0; bus.dir = 1'b0;
    for (int i = 0; i < 22; i++) cycle();
    n_total++;
    if (dut_vec() !== {FW'(0), FW'(5), 1'b0, 1'b0})
      $display("FAIL reset_mid_pre got=%h exp=%h", dut_vec(), {FW'(0), FW'(5), 1'b0, 1'b0});
    else n_pass++;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_total++;
    if (dut_vec() !== '0) $display("FAIL reset_mid_clear got=%h exp=0", dut_vec());
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_total++;
      if (dut_vec() !== {FW'(0), FW'(i / 4), i == 4, 1'b0})
        $display("FAIL reset_mid_after edge=%0d got=%h exp=%h", i, dut_vec(), {FW'(0), FW'(i / 4), i == 4, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.enable = 1'b1; bus.adj = 1'b0; bus.dir = 1'b0; bus.sel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      bus.enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.adj = ~bus.adj;
      if ($urandom_range(0, 7) == 0)  bus.dir = ~bus.dir;
      if ($urandom_range(0, 5) == 0)  bus.sel = ~bus.sel;
      cycle();
      n_total++;
      if (dut_vec() !== mdl_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      else n_pass++;
      n_total++;
      if (bus.minutes > FW'(MIN_MAX) || bus.seconds > FW'(59))
        $display("FAIL random_range cyc=%0d got min=%0d sec=%0d", i, bus.minutes, bus.seconds);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable = 1'b0;
    bus.adj    = 1'b0;
    bus.sel    = 1'b0;
    bus.dir    = 1'b0;
    test_reset();
    test_count_up();
    test_full_wrap();
    test_down();
    test_pause();
    test_adjust();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
